router_pkt_src: RTL

//  Store-and-forward packet framer that drives the 1x3 router's input port.
//  - Accepts a command (dest addr, payload length) and a payload byte stream from the host.
//  - Buffers the whole payload first.
//  - Then sends header, payload and parity with no gaps, honouring router busy.
//  - Counts router error events for host status.

---
 rtl/router_pkt_src.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/router_pkt_src.sv
// Store-and-forward packet framer feeding the 1x3 router input port.
// A command and its whole payload are buffered first. The header, payload and
// parity bytes are then sent with no gaps, holding whenever the router is busy.
module router_pkt_src #(
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned ERR_CNT_W  = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_addr,
  input  logic [5:0]           cmd_len,
  output logic                 bad_cmd,
  input  logic                 pay_valid,
  output logic                 pay_ready,
  input  logic [7:0]           pay_data,
  output logic [7:0]           tx_data,
  output logic                 tx_pkt_valid,
  input  logic                 busy,
  input  logic                 error,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 pkt_done
);

  localparam int unsigned DEPTH = 64;
  localparam int unsigned PTR_W = 6;
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, FILL, HEADER, PAYLOAD, PARITY, GAP
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           addr_q, addr_d;
  logic [5:0]           len_q, len_d;
  logic [PTR_W-1:0]     wptr_q, wptr_d;
  logic [PTR_W-1:0]     rptr_q, rptr_d;
  logic [7:0]           parity_q, parity_d;
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 pay_ready_q, pay_ready_d;
  logic                 bad_cmd_q, bad_cmd_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_pkt_valid_q, tx_pkt_valid_d;
  logic                 pkt_done_q, pkt_done_d;
  logic                 error_q, error_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  logic [7:0]           mem_q [DEPTH];
  logic                 mem_we;
  logic [PTR_W-1:0]     mem_waddr;
  logic [7:0]           mem_wdata;

  assign cmd_ready    = cmd_ready_q;
  assign pay_ready    = pay_ready_q;
  assign bad_cmd      = bad_cmd_q;
  assign tx_data      = tx_data_q;
  assign tx_pkt_valid = tx_pkt_valid_q;
  assign pkt_done     = pkt_done_q;
  assign err_count    = err_count_q;

  // Framer next-state and registered-output logic.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    len_d          = len_q;
    wptr_d         = wptr_q;
    rptr_d         = rptr_q;
    parity_d       = parity_q;
    gap_cnt_d      = gap_cnt_q;
    cmd_ready_d    = cmd_ready_q;
    pay_ready_d    = pay_ready_q;
    bad_cmd_d      = 1'b0;
    tx_data_d      = tx_data_q;
    tx_pkt_valid_d = tx_pkt_valid_q;
    pkt_done_d     = 1'b0;
    mem_we         = 1'b0;
    mem_waddr      = wptr_q;
    mem_wdata      = pay_data;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          if (cmd_addr == 2'd3 || cmd_len == 6'd0) begin
            bad_cmd_d = 1'b1;
          end else begin
            addr_d      = cmd_addr;
            len_d       = cmd_len;
            parity_d    = {cmd_len, cmd_addr};
            wptr_d      = '0;
            cmd_ready_d = 1'b0;
            pay_ready_d = 1'b1;
            state_d     = FILL;
          end
        end
      end
      FILL: begin
        if (pay_valid && pay_ready_q) begin
          mem_we   = 1'b1;
          parity_d = parity_q ^ pay_data;
          wptr_d   = wptr_q + PTR_W'(1);
          if (wptr_q == PTR_W'(len_q - 6'd1)) begin
            pay_ready_d    = 1'b0;
            tx_data_d      = {len_q, addr_q};
            tx_pkt_valid_d = 1'b1;
            state_d        = HEADER;
          end
        end
      end
      HEADER: begin
        if (!busy) begin
          tx_data_d = mem_q[PTR_W'(0)];
          rptr_d    = PTR_W'(1);
          state_d   = PAYLOAD;
        end
      end
      PAYLOAD: begin
        // rptr_q is the index of the byte after the one now on tx_data.
        if (!busy) begin
          if (rptr_q == PTR_W'(len_q)) begin
            tx_data_d      = parity_q;
            tx_pkt_valid_d = 1'b0;
            state_d        = PARITY;
          end else begin
            tx_data_d = mem_q[rptr_q];
            rptr_d    = rptr_q + PTR_W'(1);
          end
        end
      end
      PARITY: begin
        if (!busy) begin
          pkt_done_d = 1'b1;
          tx_data_d  = 8'd0;
          gap_cnt_d  = '0;
          state_d    = GAP;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Saturating count of router error rising edges.
  always_comb begin
    error_d     = error;
    err_count_d = err_count_q;
    if (error && !error_q && (err_count_q != {ERR_CNT_W{1'b1}})) begin
      err_count_d = err_count_q + ERR_CNT_W'(1);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      len_q          <= '0;
      wptr_q         <= '0;
      rptr_q         <= '0;
      parity_q       <= '0;
      gap_cnt_q      <= '0;
      cmd_ready_q    <= 1'b1;
      pay_ready_q    <= 1'b0;
      bad_cmd_q      <= 1'b0;
      tx_data_q      <= '0;
      tx_pkt_valid_q <= 1'b0;
      pkt_done_q     <= 1'b0;
      error_q        <= 1'b0;
      err_count_q    <= '0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      len_q          <= len_d;
      wptr_q         <= wptr_d;
      rptr_q         <= rptr_d;
      parity_q       <= parity_d;
      gap_cnt_q      <= gap_cnt_d;
      cmd_ready_q    <= cmd_ready_d;
      pay_ready_q    <= pay_ready_d;
      bad_cmd_q      <= bad_cmd_d;
      tx_data_q      <= tx_data_d;
      tx_pkt_valid_q <= tx_pkt_valid_d;
      pkt_done_q     <= pkt_done_d;
      error_q        <= error_d;
      err_count_q    <= err_count_d;
    end
  end

  // Payload buffer; contents are don't-care until rewritten by the next fill.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

endmodule
